shift_arbiter: RTL
==================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 means requester 0 always wins a tie.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a shift operation pending.
REQ-006 req0_data  input  32  requester 0 operand.
REQ-007 req0_sha  input  5  requester 0 shift amount, 0..31.
REQ-008 req0_dir  input  1  requester 0 direction: 0 is logical left, 1 is logical right.
REQ-009 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-010 req1_valid, req1_data, req1_sha, req1_dir, req1_ready SHALL match REQ-005 to REQ-009 for requester 1.
REQ-011 sh_in  output  32  operand driven to the shared external 32-bit left shifter.
REQ-012 sh_sha  output  5  shift amount driven to the shared shifter.
REQ-013 sh_out  input  32  combinational result returned by the shared shifter.
REQ-014 res_valid  output  1  result available.
REQ-015 res_data  output  32  shifted result.
REQ-016 res_id  output  1  index of the requester that owns res_data.
REQ-017 res_ready  input  1  consumer accepts the result.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-019 IDLE: grant is computed combinationally from the two valids, the priority pointer and FIXED_PRIO; only the granted reqN_ready SHALL be 1.
- If no request is valid, both readys SHALL be 0.
REQ-020 Tie rule, both valids high in IDLE:
- FIXED_PRIO=1: grant requester 0.
- FIXED_PRIO=0: grant the requester named by rr_ptr.
REQ-021 Accept edge (IDLE with reqN_valid & reqN_ready): the block SHALL latch data, sha, dir and id, then move to EXEC.
REQ-022 Operand preparation: the latched operand SHALL be bit-reversed when dir=1 and passed unchanged when dir=0.
- sh_in and sh_sha SHALL be driven from the prepared registers in every state.
REQ-023 EXEC: at the next edge, capture sh_out into res_data, bit-reversed again if dir=1; set res_valid=1; move to DONE.
REQ-024 DONE: res_valid, res_data and res_id SHALL hold stable until res_ready=1.
- On that edge: res_valid goes to 0, state returns to IDLE, and rr_ptr is set to the inverse of res_id.
REQ-025 Both readys SHALL be 0 in EXEC and in DONE, so only one operation is in flight at a time.
REQ-026 Latency: res_valid SHALL rise on the second rising edge after the accept edge; minimum spacing between accepts is 3 cycles.
REQ-027 sha=0 SHALL return the operand unchanged in both directions.
- sha=31 SHALL leave only bit 0 moved to bit 31 (left) or bit 31 moved to bit 0 (right); all other bits are zero.
REQ-028 A valid deasserted before acceptance SHALL cancel that request with no side effect.
REQ-029 res_ready held high in DONE SHALL complete the handshake in that cycle; res_ready outside DONE SHALL be ignored.
REQ-030 Arithmetic: no sign extension; vacated bits SHALL be zero; shift amounts are 5 bits, so no modulo or wrap is needed.

Reset
REQ-031 When reset is sampled high, the block SHALL set the following on the same edge:
- state = IDLE, rr_ptr = 0;
- res_valid, res_data, res_id = 0;
- all latched operand registers, and therefore sh_in and sh_sha, = 0.
REQ-032 Reset in EXEC or DONE SHALL discard the in-flight operation with no result emitted.
- The first accept after reset follows REQ-019 to REQ-021.
REQ-033 While reset is high, req0_ready and req1_ready SHALL be 0.

Verification
REQ-034 Left shift: req0 data=0x0000_00F1, sha=4, dir=0, res_ready=1 -> res_valid two edges after accept; res_data=0x0000_0F10; res_id=0.
REQ-035 Right shift: req1 data=0x8000_0001, sha=31, dir=1 -> res_data=0x0000_0001; res_id=1.
- Repeat with sha=0 -> res_data=0x8000_0001.
REQ-036 Round-robin, FIXED_PRIO=0, both valids held continuously -> grant order 0,1,0,1 over 4 operations.
- Run again with FIXED_PRIO=1 -> grant order 0,0,0,0.
REQ-037 Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid, res_data and res_id stable, both readys 0.
- res_ready=1 -> IDLE on the next edge.
REQ-038 Reset mid-operation: assert reset during EXEC -> next cycle res_valid=0 and state IDLE.
- A subsequent req1-only request is granted, returns its correct result, and nothing from the dropped operation appears.

Source files
------------

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester arbiter in front of a shared external 32-bit
// left shifter. Right shifts reuse the left shifter by bit-reversing the
// operand on the way in and the result on the way out.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/data/sha/dir    requester N operation (dir 0 = left, 1 = right)
//   reqN_ready                 requester N accepted this cycle
//   sh_in, sh_sha              operand / amount to the shared shifter
//   sh_out                     combinational result from the shared shifter
//   res_valid/data/id          result and owning requester
//   res_ready                  consumer accepts the result
module shift_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_sha,
  input  logic        req0_dir,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_sha,
  input  logic        req1_dir,
  output logic        req1_ready,
  output logic [31:0] sh_in,
  output logic [4:0]  sh_sha,
  input  logic [31:0] sh_out,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_id,
  input  logic        res_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [31:0] op_q, op_d;
  logic [4:0]  sha_q, sha_d;
  logic        dir_q, dir_d;
  logic        id_q, id_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_id_q, res_id_d;

  logic        gnt_vld;
  logic        gnt_id;
  logic [31:0] sel_data;
  logic [4:0]  sel_sha;
  logic        sel_dir;

  function automatic logic [31:0] bitrev(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    sha_d       = sha_q;
    dir_d       = dir_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    gnt_vld     = 1'b0;
    gnt_id      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    sel_data    = req0_data;
    sel_sha     = req0_sha;
    sel_dir     = req0_dir;

    case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = FIXED_PRIO ? 1'b0 : rr_ptr_q;
        end else if (req0_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end else if (req1_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
        if (gnt_id) begin
          sel_data = req1_data;
          sel_sha  = req1_sha;
          sel_dir  = req1_dir;
        end
        // Ready is only raised for the granted valid requester, so ready
        // alone marks the accept edge.
        if (gnt_vld && !reset) begin
          req0_ready = ~gnt_id;
          req1_ready = gnt_id;
          op_d       = sel_dir ? bitrev(sel_data) : sel_data;
          sha_d      = sel_sha;
          dir_d      = sel_dir;
          id_d       = gnt_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = dir_q ? bitrev(sh_out) : sh_out;
        res_valid_d = 1'b1;
        res_id_d    = id_q;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = ~res_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      op_q        <= '0;
      sha_q       <= '0;
      dir_q       <= 1'b0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      sha_q       <= sha_d;
      dir_q       <= dir_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign sh_in     = op_q;
  assign sh_sha    = sha_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule
